// File: rtl/mem_resp_pkg.sv
// Shared types and helpers for the multicycle memory responder:
// size encodings, FSM states, byte-enable and store-data lane alignment.
package mem_resp_pkg;

   typedef enum logic [1:0] {
      SZ_WORD = 2'b00,
      SZ_HALF = 2'b01,
      SZ_BYTE = 2'b10,
      SZ_ILL  = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   typedef struct packed {
      logic        write;
      logic [31:0] addr;
      size_e       size;
      logic [31:0] wdata;
   } req_t;

   function automatic logic [3:0] size_to_be(input size_e size, input logic [1:0] lane);
      case (size)
         SZ_WORD: return 4'hF;
         SZ_HALF: return lane[1] ? 4'hC : 4'h3;
         SZ_BYTE: return 4'b0001 << lane;
         default: return 4'h0;
      endcase
   endfunction

   // Replicate right-aligned store data into every lane; the byte enable picks the live one.
   function automatic logic [31:0] align_wdata(input size_e size, input logic [31:0] wdata);
      case (size)
         SZ_WORD: return wdata;
         SZ_HALF: return {2{wdata[15:0]}};
         default: return {4{wdata[7:0]}};
      endcase
   endfunction

endpackage

// File: rtl/mem_resp_array.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module mem_resp_array #(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          en_i,
   input  logic [3:0]    we_i,
   input  logic [AW-1:0] addr_i,
   input  logic [31:0]   wdata_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] mem [DEPTH];
   logic [31:0] rdata_q;

   // NOTE: storage arrays get no reset so they map onto plain RAM macros; only control state is reset.
   always_ff @(posedge clk_i) begin
      if (en_i) begin
         for (int k = 0; k < 4; k++) begin
            if (we_i[k]) mem[addr_i][8*k +: 8] <= wdata_i[8*k +: 8];
         end
         rdata_q <= mem[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Request/response memory slave: accepts one access, waits WAIT_CYCLES, commits or reads
// on the edge entering RESP, and pulses the response for one cycle after RESP.
module mem_responder
   import mem_resp_pkg::*;
#(
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [1:0]  req_size,
   input  logic [31:0] req_wdata,
   output logic        req_ready,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int          AW         = $clog2(DEPTH);
   localparam logic [3:0]  CNT_INIT   = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
   localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH * 4);

   state_e        state_q, state_d;
   req_t          req_q, req_d, cur;
   logic [3:0]    cnt_q, cnt_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic          rsp_err_q, rsp_err_d;
   logic [31:0]   rsp_rdata_q, rsp_rdata_d;
   logic          err;
   logic          mem_en;
   logic [3:0]    mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata, mem_rdata;

   // In IDLE the live request drives the RAM so a zero-wait access can commit on its accept edge.
   always_comb begin
      if (state_q == IDLE) begin
         cur.write = req_write;
         cur.addr  = req_addr;
         cur.size  = size_e'(req_size);
         cur.wdata = req_wdata;
      end else begin
         cur = req_q;
      end
   end

   assign err = (cur.size == SZ_ILL)
             || (cur.size == SZ_WORD && cur.addr[1:0] != 2'b00)
             || (cur.size == SZ_HALF && cur.addr[0])
             || (cur.addr >= ADDR_LIMIT);

   // NOTE: every always_comb output is defaulted first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               req_d   = cur;
               cnt_d   = CNT_INIT;
               state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) state_d = RESP;
            else               cnt_d   = cnt_q - 4'd1;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign mem_en    = (state_d == RESP) && !reset;
   assign mem_we    = (cur.write && !err) ? size_to_be(cur.size, cur.addr[1:0]) : 4'h0;
   assign mem_addr  = cur.addr[AW+1:2];
   assign mem_wdata = align_wdata(cur.size, cur.wdata);

   always_comb begin
      rsp_valid_d = (state_q == RESP);
      rsp_err_d   = rsp_err_q;
      rsp_rdata_d = rsp_rdata_q;
      if (state_q == RESP) begin
         rsp_err_d   = err;
         rsp_rdata_d = (err || req_q.write) ? 32'h0 : mem_rdata;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         req_q       <= '0;
         cnt_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         cnt_q       <= cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   mem_resp_array #(.DEPTH(DEPTH)) u_array (
      .clk_i   (clk),
      .en_i    (mem_en),
      .we_i    (mem_we),
      .addr_i  (mem_addr),
      .wdata_i (mem_wdata),
      .rdata_o (mem_rdata)
   );

   assign req_ready = (state_q == IDLE);
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a WAIT_CYCLES=2 instance driven from a vector table with a
// response scoreboard, and a WAIT_CYCLES=0 instance for back-to-back handshakes.
module tb_mem_responder;

   localparam int DEPTH = 256;
   localparam int W2    = 2;

   logic        clk = 1'b0;
   logic        reset;

   logic        req_valid2, req_write2, req_ready2, rsp_valid2, rsp_err2;
   logic [31:0] req_addr2, req_wdata2, rsp_rdata2;
   logic [1:0]  req_size2;

   logic        req_valid0, req_write0, req_ready0, rsp_valid0, rsp_err0;
   logic [31:0] req_addr0, req_wdata0, rsp_rdata0;
   logic [1:0]  req_size0;

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          cyc;
      string       name;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [1:0]  size;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;
   vec_t vecs[16];

   mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W2)) dut2 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid2), .req_write(req_write2), .req_addr(req_addr2),
      .req_size(req_size2), .req_wdata(req_wdata2), .req_ready(req_ready2),
      .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2), .rsp_err(rsp_err2)
   );

   mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid0), .req_write(req_write0), .req_addr(req_addr0),
      .req_size(req_size0), .req_wdata(req_wdata0), .req_ready(req_ready0),
      .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Scoreboard consumer for the WAIT_CYCLES=2 instance.
   always @(negedge clk) begin
      if (rsp_valid2) begin
         if (sb.size() == 0) begin
            check("unexpected_rsp", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check({e.name, "_rdata"}, rsp_rdata2, e.rdata);
            check({e.name, "_err"}, {31'd0, rsp_err2}, {31'd0, e.err});
            check({e.name, "_latency"}, cyc, e.cyc);
         end
      end
   end

   // Called at a negedge; returns one negedge after the accept edge with req_valid dropped.
   task automatic drive2(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata,
                         input logic exp_err, input string name);
      exp_t e;
      int   t = 0;
      while (!req_ready2 && t < 50) begin
         @(negedge clk);
         t++;
      end
      check({name, "_ready"}, {31'd0, req_ready2}, 32'd1);
      e.rdata = exp_rdata;
      e.err   = exp_err;
      e.cyc   = cyc + W2 + 2;
      e.name  = name;
      sb.push_back(e);
      req_valid2 = 1'b1;
      req_write2 = wr;
      req_addr2  = addr;
      req_size2  = size;
      req_wdata2 = wdata;
      @(negedge clk);
      req_valid2 = 1'b0;
   endtask

   task automatic drain2();
      int t = 0;
      while (sb.size() != 0 && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (sb.size() != 0) begin
         check("rsp_timeout", sb.size(), 0);
         sb.delete();
      end
      @(negedge clk);
   endtask

   task automatic txn2(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                       input logic [31:0] wdata, input logic [31:0] exp_rdata,
                       input logic exp_err, input string name);
      drive2(wr, addr, size, wdata, exp_rdata, exp_err, name);
      drain2();
   endtask

   function automatic logic [31:0] b2b_data(input int k);
      return 32'hA5A50000 + 32'(k * 32'h111);
   endfunction

   // Three word accesses with req_valid held high on the zero-wait instance.
   task automatic b2b0(input logic wr, input string name);
      logic [0:6] exp_rdy = 7'b1010101;
      logic [0:6] exp_vld = 7'b0010101;
      req_valid0 = 1'b1;
      req_write0 = wr;
      req_size0  = 2'b00;
      req_addr0  = 32'h80;
      req_wdata0 = b2b_data(0);
      for (int i = 0; i < 7; i++) begin
         check($sformatf("%s_ready%0d", name, i), {31'd0, req_ready0}, {31'd0, exp_rdy[i]});
         check($sformatf("%s_valid%0d", name, i), {31'd0, rsp_valid0}, {31'd0, exp_vld[i]});
         if (exp_vld[i]) begin
            check($sformatf("%s_rdata%0d", name, i), rsp_rdata0, wr ? 32'h0 : b2b_data(i/2 - 1));
            check($sformatf("%s_err%0d", name, i), {31'd0, rsp_err0}, 32'd0);
         end
         if (i % 2 == 1) begin
            if ((i + 1) / 2 < 3) begin
               req_addr0  = 32'h80 + 32'(4 * ((i + 1) / 2));
               req_wdata0 = b2b_data((i + 1) / 2);
            end else begin
               req_valid0 = 1'b0;
            end
         end
         @(negedge clk);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;
      vecs[0]  = '{1'b1, 32'h010, 2'b00, 32'hDEADBEEF, 32'h0,        1'b0};
      vecs[1]  = '{1'b0, 32'h010, 2'b00, 32'h0,        32'hDEADBEEF, 1'b0};
      vecs[2]  = '{1'b1, 32'h020, 2'b00, 32'h11223344, 32'h0,        1'b0};
      vecs[3]  = '{1'b1, 32'h021, 2'b10, 32'h000000AA, 32'h0,        1'b0};
      vecs[4]  = '{1'b1, 32'h022, 2'b01, 32'h0000BBCC, 32'h0,        1'b0};
      vecs[5]  = '{1'b0, 32'h020, 2'b00, 32'h0,        32'hBBCCAA44, 1'b0};
      vecs[6]  = '{1'b0, 32'h021, 2'b10, 32'h0,        32'hBBCCAA44, 1'b0};
      vecs[7]  = '{1'b1, 32'h012, 2'b00, 32'hFFFFFFFF, 32'h0,        1'b1};
      vecs[8]  = '{1'b1, 32'h013, 2'b01, 32'h00001234, 32'h0,        1'b1};
      vecs[9]  = '{1'b1, 32'h010, 2'b11, 32'hFFFFFFFF, 32'h0,        1'b1};
      vecs[10] = '{1'b1, 32'h400, 2'b00, 32'hFFFFFFFF, 32'h0,        1'b1};
      vecs[11] = '{1'b1, 32'h410, 2'b00, 32'hFFFFFFFF, 32'h0,        1'b1};
      vecs[12] = '{1'b0, 32'h012, 2'b00, 32'h0,        32'h0,        1'b1};
      vecs[13] = '{1'b0, 32'h010, 2'b00, 32'h0,        32'hDEADBEEF, 1'b0};
      vecs[14] = '{1'b1, 32'h3FC, 2'b00, 32'hCAFEF00D, 32'h0,        1'b0};
      vecs[15] = '{1'b0, 32'h3FC, 2'b00, 32'h0,        32'hCAFEF00D, 1'b0};

      reset = 1'b1;
      {req_valid2, req_write2, req_addr2, req_size2, req_wdata2} = '0;
      {req_valid0, req_write0, req_addr0, req_size0, req_wdata0} = '0;
      #1;
      check("rst_ready", {31'd0, req_ready2}, 32'd1);
      check("rst_valid", {31'd0, rsp_valid2}, 32'd0);
      check("rst_rdata", rsp_rdata2, 32'd0);
      check("rst_err", {31'd0, rsp_err2}, 32'd0);
      check("rst_ready0", {31'd0, req_ready0}, 32'd1);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 16; i++) begin
         txn2(vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].wdata,
              vecs[i].exp_rdata, vecs[i].exp_err, $sformatf("vec%0d", i));
      end

      // Response fields hold after the pulse.
      repeat (3) @(negedge clk);
      check("hold_valid", {31'd0, rsp_valid2}, 32'd0);
      check("hold_rdata", rsp_rdata2, 32'hCAFEF00D);

      // Reset while in WAIT drops a pending write.
      txn2(1'b1, 32'h30, 2'b00, 32'h0, 32'h0, 1'b0, "clr30");
      req_valid2 = 1'b1;
      req_write2 = 1'b1;
      req_addr2  = 32'h30;
      req_size2  = 2'b00;
      req_wdata2 = 32'h55;
      @(negedge clk);
      req_valid2 = 1'b0;
      check("pre_rst_ready", {31'd0, req_ready2}, 32'd0);
      reset = 1'b1;
      #1;
      check("midrst_ready", {31'd0, req_ready2}, 32'd1);
      check("midrst_valid", {31'd0, rsp_valid2}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (rsp_valid2) seen++;
      end
      check("midrst_no_rsp", seen, 0);
      txn2(1'b0, 32'h30, 2'b00, 32'h0, 32'h0, 1'b0, "rd30_after_rst");

      // Inputs changed during WAIT must not affect the latched access.
      drive2(1'b1, 32'h30, 2'b00, 32'h12345678, 32'h0, 1'b0, "wr30_glitch");
      req_addr2  = 32'h10;
      req_wdata2 = 32'hFFFFFFFF;
      req_size2  = 2'b10;
      drain2();
      drive2(1'b0, 32'h30, 2'b00, 32'h0, 32'h12345678, 1'b0, "rd30_glitch");
      req_addr2  = 32'h10;
      req_write2 = 1'b1;
      req_wdata2 = 32'h0;
      drain2();
      txn2(1'b0, 32'h10, 2'b00, 32'h0, 32'hDEADBEEF, 1'b0, "rd10_final");

      // Zero-wait back-to-back: writes then reads.
      b2b0(1'b1, "b2b_wr");
      repeat (2) @(negedge clk);
      b2b0(1'b0, "b2b_rd");

      repeat (4) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
